// File: rtl/rc4_decrypt_core_if.sv
// rc4_decrypt_core_if: start/result handshake plus S-RAM, encrypted ROM and decrypted RAM ports
interface rc4_decrypt_core_if #(parameter int KEY_W = 24);
    logic             start;
    logic [KEY_W-1:0] secret_key;
    logic             busy;
    logic             done;
    logic             key_ok;
    logic [7:0]       s_addr;
    logic [7:0]       s_wdata;
    logic             s_wren;
    logic [7:0]       s_rdata;
    logic [7:0]       e_addr;
    logic [7:0]       e_rdata;
    logic [7:0]       d_addr;
    logic [7:0]       d_wdata;
    logic             d_wren;
    modport slave (
        input  start, secret_key, s_rdata, e_rdata,
        output busy, done, key_ok, s_addr, s_wdata, s_wren, e_addr, d_addr, d_wdata, d_wren
    );
    modport master (
        output start, secret_key, s_rdata, e_rdata,
        input  busy, done, key_ok, s_addr, s_wdata, s_wren, e_addr, d_addr, d_wdata, d_wren
    );
endinterface

// File: rtl/rc4_decrypt_core.sv
// rc4_decrypt_core: RC4 init/KSA/PRGA over external S-RAM, decrypting the ROM into the D-RAM
module rc4_decrypt_core #(
    parameter int KEY_BYTES   = 3,
    parameter int MSG_LEN     = 32,
    parameter int CHECK_PRINT = 1,
    parameter int EARLY_ABORT = 1
) (
    input logic               clk,
    input logic               reset_n,
    rc4_decrypt_core_if.slave bus
);
    localparam int KEY_W = 8 * KEY_BYTES;
    localparam int KIW   = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
    localparam logic [3:0] IDLE  = 4'd0,  INIT  = 4'd1,
                           K_RDI = 4'd2,  K_RDJ = 4'd3,  K_WRI = 4'd4,  K_WRJ = 4'd5,
                           P_RDI = 4'd6,  P_RDJ = 4'd7,  P_WRI = 4'd8,  P_WRJ = 4'd9,
                           P_RDT = 4'd10, P_OUT = 4'd11, DONE  = 4'd12;
    logic [3:0]     state;
    logic [7:0]     i, j, k, si, sj, ek;
    logic [KIW-1:0] kidx;
    logic [7:0]     key_b [KEY_BYTES];
    logic           ok, key_ok;
    logic [7:0]     j_ksa, j_prga, pt;
    logic           pr, stop;
    assign j_ksa  = j + bus.s_rdata + key_b[kidx];
    assign j_prga = j + bus.s_rdata;
    assign pt     = bus.s_rdata ^ ek;
    assign pr     = pt == 8'h20 || (pt >= 8'h61 && pt <= 8'h7a);
    assign stop   = k == 8'(MSG_LEN - 1) || (CHECK_PRINT != 0 && EARLY_ABORT != 0 && !pr);
    always_comb begin
        bus.busy    = state != IDLE && state != DONE;
        bus.done    = state == DONE;
        bus.key_ok  = key_ok;
        bus.s_wren  = state inside {INIT, K_WRI, K_WRJ, P_WRI, P_WRJ};
        bus.s_wdata = state == INIT ? i :
                      state inside {K_WRI, P_WRI} ? bus.s_rdata :
                      state inside {K_WRJ, P_WRJ} ? si : 8'd0;
        case (state)
            INIT, K_RDI, K_WRI, P_WRI: bus.s_addr = i;
            K_RDJ:                     bus.s_addr = j_ksa;
            K_WRJ, P_WRJ:              bus.s_addr = j;
            P_RDI:                     bus.s_addr = i + 8'd1;
            P_RDJ:                     bus.s_addr = j_prga;
            P_RDT:                     bus.s_addr = si + sj;
            default:                   bus.s_addr = 8'd0;
        endcase
        bus.e_addr  = state == P_RDI ? k : 8'd0;
        bus.d_addr  = state == P_OUT ? k : 8'd0;
        bus.d_wdata = state == P_OUT ? pt : 8'd0;
        bus.d_wren  = state == P_OUT;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            si     <= '0;
            sj     <= '0;
            ek     <= '0;
            kidx   <= '0;
            ok     <= 1'b0;
            key_ok <= 1'b0;
            for (int b = 0; b < KEY_BYTES; b++) key_b[b] <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    for (int b = 0; b < KEY_BYTES; b++) key_b[b] <= bus.secret_key[KEY_W-1-8*b -: 8];
                    i      <= '0;
                    ok     <= 1'b1;
                    key_ok <= 1'b0;
                    state  <= INIT;
                end
                INIT: begin
                    i <= i + 8'd1;
                    if (i == 8'hff) begin
                        j     <= '0;
                        kidx  <= '0;
                        state <= K_RDI;
                    end
                end
                K_RDI: state <= K_RDJ;
                K_RDJ: begin
                    si    <= bus.s_rdata;
                    j     <= j_ksa;
                    state <= K_WRI;
                end
                K_WRI: begin
                    sj    <= bus.s_rdata;
                    state <= K_WRJ;
                end
                K_WRJ: begin
                    i     <= i + 8'd1;
                    kidx  <= kidx == KIW'(KEY_BYTES - 1) ? '0 : kidx + 1'b1;
                    state <= i == 8'hff ? P_RDI : K_RDI;
                    if (i == 8'hff) begin
                        j <= '0;
                        k <= '0;
                    end
                end
                P_RDI: begin
                    i     <= i + 8'd1;
                    state <= P_RDJ;
                end
                P_RDJ: begin
                    si    <= bus.s_rdata;
                    ek    <= bus.e_rdata;
                    j     <= j_prga;
                    state <= P_WRI;
                end
                P_WRI: begin
                    sj    <= bus.s_rdata;
                    state <= P_WRJ;
                end
                P_WRJ: state <= P_RDT;
                P_RDT: state <= P_OUT;
                P_OUT: begin
                    k     <= k + 8'd1;
                    ok    <= ok & pr;
                    state <= stop ? DONE : P_RDI;
                    if (stop) key_ok <= CHECK_PRINT == 0 || (ok && pr);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rc4_decrypt_core.sv
// tb_rc4_decrypt_core: several core configurations against a plain RC4 reference model
module tb_rc4_decrypt_core;
    localparam int NI = 5;
    localparam int KB [NI] = '{4, 3, 3, 6, 1};
    localparam int ML [NI] = '{5, 9, 9, 14, 1};
    localparam int CP [NI] = '{1, 0, 1, 1, 1};
    localparam int EA [NI] = '{1, 0, 1, 0, 0};
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    logic [NI-1:0]       start_v;
    logic [127:0]        key_v [NI];
    logic [7:0]          e_rom [NI][256];
    logic [NI-1:0]       busy_v, done_v, key_ok_v, s_wren_v, d_wren_v;
    logic [NI-1:0][7:0]  s_addr_v, d_addr_v, d_wdata_v;
    int                  tests = 0;
    int                  fails = 0;
    logic [7:0]          exp_d [256];
    logic [7:0]          ks [256];
    int                  n_exp;
    logic                ok_exp;
    for (genvar g = 0; g < NI; g++) begin : gen
        rc4_decrypt_core_if #(.KEY_W(8 * KB[g])) bus ();
        logic [7:0] s_mem [256];
        rc4_decrypt_core #(
            .KEY_BYTES(KB[g]), .MSG_LEN(ML[g]), .CHECK_PRINT(CP[g]), .EARLY_ABORT(EA[g])
        ) dut (
            .clk(clk), .reset_n(reset_n), .bus(bus)
        );
        assign bus.start      = start_v[g];
        assign bus.secret_key = key_v[g][8*KB[g]-1:0];
        assign busy_v[g]      = bus.busy;
        assign done_v[g]      = bus.done;
        assign key_ok_v[g]    = bus.key_ok;
        assign s_wren_v[g]    = bus.s_wren;
        assign d_wren_v[g]    = bus.d_wren;
        assign s_addr_v[g]    = bus.s_addr;
        assign d_addr_v[g]    = bus.d_addr;
        assign d_wdata_v[g]   = bus.d_wdata;
        always @(posedge clk) begin
            if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wdata;
            bus.s_rdata <= s_mem[bus.s_addr];
            bus.e_rdata <= e_rom[g][bus.e_addr];
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic printable(input logic [7:0] p);
        return p == 8'h20 || (p >= 8'h61 && p <= 8'h7a);
    endfunction
    task automatic keystream(input int g, input logic [127:0] key);
        int s [256];
        int a, b, tmp;
        for (int n = 0; n < 256; n++) s[n] = n;
        b = 0;
        for (int n = 0; n < 256; n++) begin
            b = (b + s[n] + int'(key[8*(KB[g]-1-n%KB[g]) +: 8])) % 256;
            tmp = s[n]; s[n] = s[b]; s[b] = tmp;
        end
        a = 0;
        b = 0;
        for (int n = 0; n < ML[g]; n++) begin
            a = (a + 1) % 256;
            b = (b + s[a]) % 256;
            tmp = s[a]; s[a] = s[b]; s[b] = tmp;
            ks[n] = 8'(s[(s[a] + s[b]) % 256]);
        end
    endtask
    task automatic expect_from_rom(input int g);
        logic bad;
        bad = 1'b0;
        n_exp = 0;
        for (int n = 0; n < ML[g]; n++) begin
            exp_d[n] = e_rom[g][n] ^ ks[n];
            n_exp++;
            if (!printable(exp_d[n])) begin
                bad = 1'b1;
                if (CP[g] != 0 && EA[g] != 0) break;
            end
        end
        ok_exp = CP[g] == 0 || !bad;
    endtask
    task automatic set_ct(input int g, input int n, input logic [255:0] v);
        for (int x = 0; x < n; x++) e_rom[g][x] = v[8*(n-1-x) +: 8];
    endtask
    task automatic set_pt(input int n, input logic [255:0] v, input logic ok);
        for (int x = 0; x < n; x++) exp_d[x] = v[8*(n-1-x) +: 8];
        n_exp = n;
        ok_exp = ok;
    endtask
    task automatic run(input int g, input logic [127:0] key, input bit disturb);
        int cyc, nw;
        @(negedge clk);
        key_v[g] = key;
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        cyc = 1;
        nw = 0;
        chk("busy_after_start", busy_v[g], 1);
        while (!done_v[g] && cyc < 4000) begin
            if (d_wren_v[g]) begin
                chk("d_addr", d_addr_v[g], nw);
                chk("d_wdata", d_wdata_v[g], exp_d[nw & 255]);
                nw++;
            end
            if (disturb && cyc == 700) begin
                start_v[g] = 1'b1;
                key_v[g] = ~key;
            end
            if (disturb && cyc == 701) start_v[g] = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done_v[g], 1);
        chk("latency", cyc, 1 + 256 + 1024 + 6 * n_exp);
        chk("n_writes", nw, n_exp);
        chk("key_ok", key_ok_v[g], ok_exp);
        chk("busy_at_done", busy_v[g], 0);
        @(negedge clk);
        chk("done_pulse", done_v[g], 0);
        chk("key_ok_held", key_ok_v[g], ok_exp);
    endtask
    initial begin
        logic [127:0] key;
        int g;
        start_v = '0;
        for (int n = 0; n < NI; n++) begin
            key_v[n] = '0;
            for (int x = 0; x < 256; x++) e_rom[n][x] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_v, 0);
        chk("rst_done", done_v, 0);
        chk("rst_key_ok", key_ok_v, 0);
        chk("rst_s_wren", s_wren_v, 0);
        chk("rst_d_wren", d_wren_v, 0);
        chk("rst_s_addr", s_addr_v, 0);
        reset_n = 1'b1;
        set_ct(0, 5, 40'h1021BF0420);
        set_pt(5, "pedia", 1'b1);
        run(0, 128'h57696B69, 1'b0);
        set_ct(1, 9, 72'hBBF316E8D940AF0AD3);
        set_pt(9, "Plaintext", 1'b1);
        run(1, 128'h4B6579, 1'b0);
        set_ct(2, 9, 72'hBBF316E8D940AF0AD3);
        set_pt(1, 8'h50, 1'b0);
        run(2, 128'h4B6579, 1'b0);
        set_ct(3, 14, 112'h45A01F645FC35B383552544B9BF5);
        set_pt(14, "Attack at dawn", 1'b0);
        run(3, 128'h536563726574, 1'b0);
        // reset in the middle of KSA must abandon the run silently
        @(negedge clk);
        key_v[0] = 128'h57696B69;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (600) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", busy_v[0], 0);
        chk("abort_s_wren", s_wren_v[0], 0);
        chk("abort_s_addr", s_addr_v[0], 0);
        chk("abort_key_ok", key_ok_v[0], 0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("abort_no_done", done_v, 0);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_idle_done", done_v[0], 0);
        chk("abort_idle_busy", busy_v[0], 0);
        set_pt(5, "pedia", 1'b1);
        run(0, 128'h57696B69, 1'b0);
        set_pt(5, "pedia", 1'b1);
        run(0, 128'h57696B69, 1'b1);
        for (int r = 0; r < 12; r++) begin
            g = $urandom_range(0, NI - 1);
            key = {$urandom, $urandom, $urandom, $urandom};
            keystream(g, key);
            for (int x = 0; x < ML[g]; x++) begin
                int c;
                c = $urandom_range(0, 26);
                e_rom[g][x] = r % 2 == 0 ? 8'($urandom) : ks[x] ^ (c == 26 ? 8'h20 : 8'(8'h61 + c));
            end
            expect_from_rom(g);
            run(g, key, 1'b0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
